imem_loader: RTL and testbench

- Program loader: the writer side of the instruction-memory interface that the single-cycle MIPS core reads.
- Accepts a byte stream on a valid/ready link, assembles big-endian 32-bit words and writes them sequentially into instruction memory from address 0.
- Holds the core's PC in clear until a load completes cleanly, so the core fetches only a fully written program.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 42 ++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents: loader state encoding, bytes per instruction word and the
// byte-stream width.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer: shifts accepted bytes in MSB-first and flags the
// byte that completes a big-endian 32-bit word.
// Ports:
//   i_clk         system clock
//   i_clr_n       synchronous active-low reset
//   i_clear       restart packing at byte 0 (load start)
//   i_accept      a byte is consumed this cycle
//   i_byte        byte data
//   o_word_ready  this accepted byte completes a word
//   o_word        assembled word (complete the cycle after o_word_ready)
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_clr_n,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_word_ready,
    output logic [WORD_W-1:0] o_word
);

    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            r_word <= {r_word[WORD_W-BYTE_W-1:0], i_byte};
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_word_ready = i_accept && (r_idx == 2'(BYTES_PER_WORD - 1));
    assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader. Takes a length byte N followed by
// 4*N big-endian instruction bytes on a valid/ready link and writes the
// words to instruction memory from address 0. The core's PC is held in
// clear until a load finishes without error.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over the data bytes; a mismatch flags err.
// Ports:
//   i_clk, i_clr_n      clock, synchronous active-low reset
//   i_start             begin a load (honoured in IDLE or DONE only)
//   i_in_valid/i_in_byte/o_in_ready  byte stream
//   o_wr_en/o_wr_addr/o_wr_data      instruction-memory write port
//   o_cpu_hold          core PC clear
//   o_busy/o_done/o_err load status
//   o_word_count        words written in the current or last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_clr_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [BYTE_W-1:0] i_in_byte,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);

    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = ST_CHK;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_err;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W:0]     r_word_count;
    logic [BYTE_W-1:0]   r_len;

    logic                w_in_ready;
    logic                w_xfer;
    logic                w_start_load;
    logic                w_word_ready;
    logic [WORD_W-1:0]   w_word;
    logic [31:0]         w_byte_ext;
    logic [31:0]         w_len_ext;
    logic [31:0]         w_wc_inc;

    assign w_in_ready   = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_xfer       = i_in_valid && w_in_ready;
    assign w_start_load = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_byte_ext   = 32'(i_in_byte);
    assign w_len_ext    = 32'(r_len);
    assign w_wc_inc     = 32'(r_word_count) + 32'd1;

    imem_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_clr_n      (i_clr_n),
        .i_clear      (w_start_load),
        .i_accept     (w_xfer && (r_state == ST_DATA)),
        .i_byte       (i_in_byte),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_wr_en     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_cpu_hold  = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                o_busy = 1'b1;
                if (w_xfer) begin
                    if (i_in_byte == '0)            w_state_nxt = END_STATE;
                    else if (w_byte_ext > CAPACITY) w_state_nxt = ST_DONE;
                    else                            w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                o_busy = 1'b1;
                if (w_word_ready) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                o_busy  = 1'b1;
                o_wr_en = 1'b1;
                w_state_nxt = (w_wc_inc == w_len_ext) ? END_STATE : ST_DATA;
            end
            ST_CHK: begin
                o_busy = 1'b1;
                if (w_xfer) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done     = 1'b1;
                o_cpu_hold = r_err;
                if (i_start) w_state_nxt = ST_LEN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_err        <= 1'b0;
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_len        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            if (w_start_load) begin
                r_err        <= 1'b0;
                r_wr_addr    <= '0;
                r_word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum       <= '0;
`endif
            end
            if ((r_state == ST_LEN) && w_xfer) begin
                r_len <= i_in_byte;
                if (w_byte_ext > CAPACITY) r_err <= 1'b1;
            end
            // Address wraps naturally after a full-capacity load.
            if (r_state == ST_WRITE) begin
                r_wr_addr    <= r_wr_addr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ((r_state == ST_DATA) && w_xfer) r_csum <= r_csum ^ i_in_byte;
            if ((r_state == ST_CHK) && w_xfer && (i_in_byte != r_csum)) r_err <= 1'b1;
`endif
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = w_word;
    assign o_err        = r_err;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] log_addr [16];
    logic [DATA_W-1:0] log_data [16];
    int                n_wr = 0;
    int                n_wr_rdy_bad = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk        (clk),
        .i_clr_n      (clr_n),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .i_in_byte    (in_byte),
        .o_in_ready   (in_ready),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_cpu_hold   (cpu_hold),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            if (n_wr < 16) begin
                log_addr[n_wr] = wr_addr;
                log_data[n_wr] = wr_data;
            end
            n_wr = n_wr + 1;
            if (in_ready !== 1'b0) n_wr_rdy_bad = n_wr_rdy_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send(input logic [7:0] b, input bit toggle);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 64'(t), 64'(0));
        @(negedge clk);
        if (toggle) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (done !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("done_timeout", 64'(t), 64'(0));
    endtask

    task automatic send_prog(input bit toggle);
        send(8'h02, toggle);
        send(8'h20, toggle); send(8'h08, toggle); send(8'h00, toggle); send(8'h05, toggle);
        send(8'h01, toggle); send(8'h08, toggle); send(8'h48, toggle); send(8'h20, toggle);
`ifdef IMEM_LOADER_CHECKSUM_EN
        // 20^08^00^05^01^08^48^20 = 4C
        send(8'h4C, toggle);
`endif
    endtask

    task automatic check_prog(input string tag);
        chk({tag, "_nwr"},   64'(n_wr), 64'(2));
        chk({tag, "_a0"},    64'(log_addr[0]), 64'(0));
        chk({tag, "_d0"},    64'(log_data[0]), 64'h20080005);
        chk({tag, "_a1"},    64'(log_addr[1]), 64'(1));
        chk({tag, "_d1"},    64'(log_data[1]), 64'h01084820);
        chk({tag, "_wc"},    64'(word_count), 64'(2));
        chk({tag, "_done"},  64'(done), 64'(1));
        chk({tag, "_err"},   64'(err), 64'(0));
        chk({tag, "_hold"},  64'(cpu_hold), 64'(0));
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_waddr"}, 64'(wr_addr), 64'(2));
        chk({tag, "_rdy_in_write"}, 64'(n_wr_rdy_bad), 64'(0));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_wren"},  64'(wr_en), 64'(0));
        chk({tag, "_waddr"}, 64'(wr_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(wr_data), 64'(0));
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_done"},  64'(done), 64'(0));
        chk({tag, "_err"},   64'(err), 64'(0));
        chk({tag, "_wc"},    64'(word_count), 64'(0));
        chk({tag, "_hold"},  64'(cpu_hold), 64'(1));
    endtask

    initial begin
        // Reset
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        clr_n = 1'b1;
        @(negedge clk);
        check_reset("idle");

        // Two-word load, valid held high
        n_wr = 0; n_wr_rdy_bad = 0;
        do_start();
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_ready", 64'(in_ready), 64'(1));
        chk("start_hold", 64'(cpu_hold), 64'(1));
        send_prog(1'b0);
        wait_done();
        check_prog("held");

        // Same program, valid toggling, restarted from DONE
        n_wr = 0; n_wr_rdy_bad = 0;
        do_start();
        chk("restart_done_clr", 64'(done), 64'(0));
        chk("restart_wc_clr", 64'(word_count), 64'(0));
        send_prog(1'b1);
        wait_done();
        check_prog("toggle");

        // Oversize length 0x41
        n_wr = 0;
        do_start();
        send(8'h41, 1'b0);
        wait_done();
        chk("big_nwr", 64'(n_wr), 64'(0));
        chk("big_done", 64'(done), 64'(1));
        chk("big_err", 64'(err), 64'(1));
        chk("big_hold", 64'(cpu_hold), 64'(1));

        // Zero length
        n_wr = 0;
        do_start();
        chk("zero_err_clr", 64'(err), 64'(0));
        send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00, 1'b0);
`endif
        wait_done();
        chk("zero_nwr", 64'(n_wr), 64'(0));
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_err", 64'(err), 64'(0));
        chk("zero_hold", 64'(cpu_hold), 64'(0));
        chk("zero_wc", 64'(word_count), 64'(0));

        // Reset after 6 data bytes
        n_wr = 0;
        do_start();
        send(8'h02, 1'b0);
        send(8'h20, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        send(8'h01, 1'b0); send(8'h08, 1'b0);
        in_valid = 1'b0;
        clr_n = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_nwr", 64'(n_wr), 64'(1));
        chk("midrst_d0", 64'(log_data[0]), 64'h20080005);
        chk("midrst_idle_hold", 64'(cpu_hold), 64'(1));

        // Reload after the aborted load
        n_wr = 0; n_wr_rdy_bad = 0;
        do_start();
        send_prog(1'b0);
        wait_done();
        check_prog("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // One-word load with bad then good checksum
        n_wr = 0;
        do_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        wait_done();
        chk("csum_bad_err", 64'(err), 64'(1));
        chk("csum_bad_hold", 64'(cpu_hold), 64'(1));
        chk("csum_bad_nwr", 64'(n_wr), 64'(1));

        n_wr = 0;
        do_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        wait_done();
        chk("csum_ok_err", 64'(err), 64'(0));
        chk("csum_ok_hold", 64'(cpu_hold), 64'(0));
        chk("csum_ok_d0", 64'(log_data[0]), 64'h00000001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
